// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the async-FIFO pointer/flag blocks.
//   depth_of(w) : FIFO depth for an address width w (2^w)
//   bin2gray(b) : reflected binary -> Gray
//   gray2bin(g) : Gray -> binary
// Functions work on a MAXW-wide container; callers zero-extend their
// pointer in and cast the result back to their own pointer width. Both
// conversions are unaffected by zero upper bits, so this is exact.
package fifo_pkg;

  localparam int MAXW = 32;

  function automatic int unsigned depth_of(input int unsigned w);
    return 32'd1 << w;
  endfunction

  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: combinational Gray -> binary converter, W bits.
//   i_gray : Gray-coded input
//   o_bin  : binary equivalent (prefix XOR from the MSB down)
module fifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  assign o_bin[W-1] = i_gray[W-1];

  for (genvar i = W - 2; i >= 0; i--) begin : g_bit
    assign o_bin[i] = o_bin[i+1] ^ i_gray[i];
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side pointer and full/almost-full/free-count logic
// of an asynchronous FIFO, all in the write clock domain.
//   clk          : write clock (posedge)
//   rst          : synchronous active-high reset
//   winc         : write request
//   wq2_rptr     : Gray read pointer, already synchronised into clk domain
//   ovf_clr      : clears the sticky overflow flag
//   wen          : memory write enable (winc & ~wfull, forced 0 in reset)
//   waddr        : memory write address (low WIDTH bits of binary pointer)
//   wptr         : registered Gray write pointer for the read domain
//   wfull        : registered full flag
//   walmost_full : registered, free slots <= AFULL_THRESH
//   wfree        : registered free-slot count, 0..DEPTH
//   woverflow    : sticky, write attempted while full
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int WIDTH        = 3,
  parameter int AFULL_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [WIDTH:0]   wq2_rptr,
  input  logic             ovf_clr,
  output logic             wen,
  output logic [WIDTH-1:0] waddr,
  output logic [WIDTH:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [WIDTH:0]   wfree,
  output logic             woverflow
);

  localparam int             PW      = WIDTH + 1;
  localparam logic [PW-1:0]  DEPTH_P = PW'(depth_of(WIDTH));
  localparam logic [PW-1:0]  AF_P    = PW'(AFULL_THRESH);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr;
  logic          r_wfull;
  logic          r_afull;
  logic [PW-1:0] r_wfree;
  logic          r_ovf;

  logic          w_wen;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_full_cmp;
  logic [PW-1:0] w_free_next;
  logic          w_full_next;
  logic          w_afull_next;

  // Reset overrides any write request in the same cycle.
  assign w_wen       = winc & ~r_wfull & ~rst;
  assign w_wbin_next = r_wbin + {{WIDTH{1'b0}}, w_wen};
  assign w_gray_next = PW'(bin2gray(MAXW'(w_wbin_next)));

  fifo_gray2bin #(.W(PW)) u_rg2b (
    .i_gray (wq2_rptr),
    .o_bin  (w_rbin)
  );

  // Full when the write pointer is exactly one lap ahead of the read
  // pointer: in Gray that is the top two bits inverted, the rest equal.
  // wq2_rptr lags the real read pointer, so this can only be late to
  // clear, never early.
  assign w_full_cmp   = {~wq2_rptr[WIDTH:WIDTH-1], wq2_rptr[WIDTH-2:0]};
  assign w_full_next  = (w_gray_next == w_full_cmp);

  // Occupancy is the modular pointer difference; free = DEPTH - occupancy.
  assign w_free_next  = DEPTH_P - (w_wbin_next - w_rbin);
  assign w_afull_next = (w_free_next <= AF_P);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbin  <= '0;
      r_wptr  <= '0;
      r_wfull <= 1'b0;
      r_afull <= 1'b0;
      r_wfree <= DEPTH_P;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wptr  <= w_gray_next;
      r_wfull <= w_full_next;
      r_afull <= w_afull_next;
      r_wfree <= w_free_next;
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                  r_ovf <= 1'b0;
    else if (winc && r_wfull) r_ovf <= 1'b1;
    else if (ovf_clr)         r_ovf <= 1'b0;
  end

  assign wen          = w_wen;
  assign waddr        = r_wbin[WIDTH-1:0];
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign walmost_full = r_afull;
  assign wfree        = r_wfree;
  assign woverflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_full.sv
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       winc = 1'b0;
  logic [3:0] wq2_rptr = 4'd0;
  logic       ovf_clr = 1'b0;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wfree;
  logic       woverflow;

  int checks = 0;
  int passed = 0;

  fifo_wptr_full #(.WIDTH(3), .AFULL_THRESH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .ovf_clr      (ovf_clr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wfree        (wfree),
    .woverflow    (woverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] fill_gray [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100};
  logic [3:0] b, rb, prev;
  logic [3:0] x;

  initial begin
    // Reset with winc held high
    rst = 1'b1; winc = 1'b1; #1;
    chk("rst_wen_pre", {31'd0, wen}, 0);
    step(); step();
    chk("rst_wptr", {28'd0, wptr}, 0);
    chk("rst_waddr", {29'd0, waddr}, 0);
    chk("rst_wfull", {31'd0, wfull}, 0);
    chk("rst_wfree", {28'd0, wfree}, 8);
    chk("rst_afull", {31'd0, walmost_full}, 0);
    chk("rst_ovf", {31'd0, woverflow}, 0);
    chk("rst_wen", {31'd0, wen}, 0);

    // Fill with read pointer parked at 0
    rst = 1'b0; wq2_rptr = 4'b0000; winc = 1'b1; #1;
    for (int i = 1; i <= 8; i++) begin
      chk("fill_wen", {31'd0, wen}, 1);
      chk("fill_waddr", {29'd0, waddr}, i - 1);
      step();
      chk("fill_wptr", {28'd0, wptr}, {28'd0, fill_gray[i-1]});
      chk("fill_wfree", {28'd0, wfree}, 8 - i);
      chk("fill_afull", {31'd0, walmost_full}, (i >= 6) ? 1 : 0);
      chk("fill_wfull", {31'd0, wfull}, (i == 8) ? 1 : 0);
    end

    // Overflow handling
    chk("ovf_wen", {31'd0, wen}, 0);
    step();
    chk("ovf_wptr", {28'd0, wptr}, 4'b1100);
    chk("ovf_waddr", {29'd0, waddr}, 0);
    chk("ovf_set", {31'd0, woverflow}, 1);
    chk("ovf_full", {31'd0, wfull}, 1);
    winc = 1'b0; step();
    chk("ovf_hold", {31'd0, woverflow}, 1);
    ovf_clr = 1'b1; step();
    chk("ovf_clr", {31'd0, woverflow}, 0);
    winc = 1'b1; step();
    chk("ovf_set_prio", {31'd0, woverflow}, 1);
    chk("ovf_prio_wptr", {28'd0, wptr}, 4'b1100);
    winc = 1'b0; ovf_clr = 1'b0; step();
    chk("ovf_hold2", {31'd0, woverflow}, 1);

    // Drain: read pointer advances to 4
    wq2_rptr = 4'b0110; step();
    chk("drain_wfull", {31'd0, wfull}, 0);
    chk("drain_afull", {31'd0, walmost_full}, 0);
    chk("drain_wfree", {28'd0, wfree}, 4);

    // Write and read advance together: free count unchanged
    winc = 1'b1; wq2_rptr = 4'b0111; #1;
    chk("sim_wen", {31'd0, wen}, 1);
    step();
    chk("sim_wfree", {28'd0, wfree}, 4);
    chk("sim_wptr", {28'd0, wptr}, 4'b1101);
    chk("sim_waddr", {29'd0, waddr}, 1);

    // Clean reset, then 5 writes, then reset mid-operation
    winc = 1'b0; wq2_rptr = 4'b0000; rst = 1'b1; step();
    rst = 1'b0; winc = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mid_pre_wptr", {28'd0, wptr}, 4'b0111);
    chk("mid_pre_wfree", {28'd0, wfree}, 3);
    rst = 1'b1; #1;
    chk("mid_wen", {31'd0, wen}, 0);
    step();
    chk("mid_wptr", {28'd0, wptr}, 0);
    chk("mid_waddr", {29'd0, waddr}, 0);
    chk("mid_wfull", {31'd0, wfull}, 0);
    chk("mid_wfree", {28'd0, wfree}, 8);
    chk("mid_afull", {31'd0, walmost_full}, 0);
    chk("mid_ovf", {31'd0, woverflow}, 0);
    rst = 1'b0; #1;
    chk("post_wen", {31'd0, wen}, 1);
    chk("post_waddr", {29'd0, waddr}, 0);
    step();
    chk("post_wptr", {28'd0, wptr}, 4'b0001);
    chk("post_wfree", {28'd0, wfree}, 7);

    // Wrap: 20 writes, read pointer two behind
    b = 4'd1;
    prev = wptr;
    for (int i = 0; i < 20; i++) begin
      rb = b - 4'd1;
      wq2_rptr = g(rb);
      step();
      b = b + 4'd1;
      chk("wrap_wptr", {28'd0, wptr}, {28'd0, g(b)});
      x = wptr ^ prev;
      chk("wrap_onebit", {31'd0, (x != 0) && ((x & (x - 4'd1)) == 0)}, 1);
      chk("wrap_wfull", {31'd0, wfull}, 0);
      chk("wrap_wfree", {28'd0, wfree}, 6);
      prev = wptr;
    end
    chk("wrap_final_waddr", {29'd0, waddr}, 5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 3, address width; FIFO depth DEPTH = 2^WIDTH; pointer width WIDTH+1; legal WIDTH >= 2.
REQ-002 The block SHALL have one parameter: AFULL_THRESH, default 2, almost-full free-slot threshold; legal range 0..DEPTH-1.
REQ-003 Port: clk  in  1  single write-domain clock; all logic on posedge clk.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: winc  in  1  write request.
REQ-006 Port: wq2_rptr  in  WIDTH+1  read pointer, Gray-coded, already double-flopped into clk domain.
REQ-007 Port: ovf_clr  in  1  clears sticky overflow flag.
REQ-008 Port: wen  out  1  memory write enable, combinational = winc & ~wfull.
REQ-009 Port: waddr  out  WIDTH  memory write address = wbin[WIDTH-1:0].
REQ-010 Port: wptr  out  WIDTH+1  registered Gray write pointer, sent to read-domain synchronizer.
REQ-011 Port: wfull  out  1  registered full flag.
REQ-012 Port: walmost_full  out  1  registered, high when free slots <= AFULL_THRESH.
REQ-013 Port: wfree  out  WIDTH+1  registered free-slot count, 0..DEPTH.
REQ-014 Port: woverflow  out  1  sticky, set on write attempt while full.

Function
REQ-015 Internal binary pointer wbin (WIDTH+1 bits); wbin_next = wbin + wen, modulo 2^(WIDTH+1).
REQ-016 wptr SHALL register bin2gray(wbin_next) = wbin_next ^ (wbin_next >> 1); wptr changes at most one bit per cycle, including wrap 2^(WIDTH+1)-1 -> 0.
REQ-017 wfull SHALL register (bin2gray(wbin_next) == {~wq2_rptr[WIDTH:WIDTH-1], wq2_rptr[WIDTH-2:0]}).
REQ-018 Latency: write accepted at edge N -> wptr, wfull, wfree, walmost_full updated at edge N (same edge, registered from next-state); wq2_rptr change -> flags updated at next edge.
REQ-019 rbin = gray2bin(wq2_rptr); wfree SHALL register DEPTH - ((wbin_next - rbin) mod 2^(WIDTH+1)).
REQ-020 walmost_full SHALL register (free_next <= AFULL_THRESH); wfull implies walmost_full.
REQ-021 Write while full (winc=1, wfull=1): wen=0, wbin/wptr/waddr unchanged, no corruption.
REQ-022 woverflow SHALL set on winc & wfull; cleared by ovf_clr; set has priority when both occur in same cycle.
REQ-023 Simultaneous write and read-pointer advance in same cycle: wfree reflects both (net unchanged if one each).
REQ-024 wfull SHALL deassert pessimistically only (never reports not-full when full), since wq2_rptr lags the true read pointer.

Reset
REQ-025 While rst=1 at posedge: wbin=0, wptr=0, wfull=0, wfree=DEPTH, walmost_full=0, woverflow=0; winc ignored.
REQ-026 Reset asserted mid-operation SHALL override any in-progress write in that cycle; first write after release lands at waddr=0.
REQ-027 wen SHALL be 0 during reset cycles regardless of winc.

Structure
REQ-028 Shared package fifo_pkg SHALL hold DEPTH derivation and bin2gray/gray2bin functions, reused by read-pointer/empty block.
REQ-029 One sub-module fifo_gray2bin (combinational, WIDTH+1 bits) SHALL convert wq2_rptr; no other hierarchy.

Verification (WIDTH=3, AFULL_THRESH=2)
REQ-030 Reset: rst=1 two cycles with winc=1 -> wptr=0000, waddr=0, wfull=0, wfree=8, woverflow=0, wen=0.
REQ-031 Fill: wq2_rptr=0000, winc=1 for 8 cycles -> wptr 0001,0011,0010,0110,0111,0101,0100,1100; walmost_full=1 after 6th write (wfree=2); wfull=1, wfree=0 after 8th.
REQ-032 Overflow: from full, winc=1 one cycle -> wen=0, wptr stays 1100, woverflow=1 and holds; ovf_clr=1 alone -> 0; ovf_clr with overflowing write -> stays 1.
REQ-033 Drain: from full, wq2_rptr=0110 (gray 4) -> next edge wfull=0, walmost_full=0, wfree=4.
REQ-034 Wrap: 20 writes with wq2_rptr tracking wptr two cycles behind -> wbin wraps 15->0 (wptr 1000->0000), single-bit Gray steps, wfull never asserts.
REQ-035 Mid-op reset: 5 writes, rst=1 one cycle with winc=1 -> all outputs at reset values; next write uses waddr=0.
